dma_wr_drain: RTL

- Downstream consumer of the DMA ping-pong data cache.
- Per burst command, reads beats out of the selected cache buffer and drives them onto the AXI4 write-data (W) channel with correct WSTRB/WLAST.
- Returns consumed byte counts to the cache so its fill levels drop.
- Sits between the cache and the AXI4 master write port; commands come from the DMA transfer engine.

---
 rtl/dma_wr_drain.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dma_wr_drain.sv
// dma_wr_drain: drains one burst per command from the ping-pong data cache
// onto the AXI4 write-data channel and returns consumed byte counts.
//
// Ports:
//   CLOCK, RESETN                  clock, asynchronous active-low reset
//   start/start_sel/start_addr/
//   start_beats/last_strb          burst command (sampled in IDLE only)
//   busy, done                     burst in progress / one-cycle completion pulse
//   cache_rd_sel/addr/data         cache read port (combinational read data)
//   cache_dec, cache_dec_bytes     fill-level decrement strobe and byte count
//   WDATA/WSTRB/WLAST/WVALID/WREADY AXI4 W channel
//   abort                          only with DMA_WR_DRAIN_ABORT_EN: remaining
//                                  beats are issued zero-filled without cache reads
module dma_wr_drain #(
    parameter  int unsigned DATA_BYTES  = 8,
    parameter  int unsigned CACHE_DEPTH = 16,
    parameter  int unsigned MAX_BURST   = 16,
    localparam int unsigned DW = DATA_BYTES * 8,
    localparam int unsigned AW = $clog2(CACHE_DEPTH),
    localparam int unsigned BW = $clog2(MAX_BURST + 1),
    localparam int unsigned CW = $clog2(DATA_BYTES) + 1
) (
    input  logic                  CLOCK,
    input  logic                  RESETN,
    input  logic                  start,
    input  logic                  start_sel,
    input  logic [AW-1:0]         start_addr,
    input  logic [BW-1:0]         start_beats,
    input  logic [DATA_BYTES-1:0] last_strb,
    output logic                  busy,
    output logic                  done,
    output logic                  cache_rd_sel,
    output logic [AW-1:0]         cache_rd_addr,
    input  logic [DW-1:0]         cache_rd_data,
    output logic                  cache_dec,
    output logic [CW-1:0]         cache_dec_bytes,
    output logic [DW-1:0]         WDATA,
    output logic [DATA_BYTES-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
`ifdef DMA_WR_DRAIN_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  WREADY
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STREAM, S_DONE} state_e;

    state_e                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [BW-1:0]         beats_q, beats_d;
    logic [DATA_BYTES-1:0] lstrb_q, lstrb_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic [DATA_BYTES-1:0] wstrb_q, wstrb_d;
    logic                  wlast_q, wlast_d;
    logic                  wvalid_q, wvalid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fetch_c;
    logic                  zero_fill_c;
    logic [DATA_BYTES-1:0] beat_strb_c;

    function automatic logic [CW-1:0] popcount(input logic [DATA_BYTES-1:0] s);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(DATA_BYTES); i++) n = n + CW'(s[i]);
        return n;
    endfunction

`ifdef DMA_WR_DRAIN_ABORT_EN
    logic abort_q, abort_d;
    // Abort is registered, so a beat already being fetched in the abort cycle stays real.
    assign zero_fill_c = abort_q;
`else
    assign zero_fill_c = 1'b0;
`endif

    // Strobe of the beat being fetched: only the final beat uses last_strb.
    assign beat_strb_c = (beats_q == BW'(1)) ? lstrb_q : '1;

    assign cache_rd_sel    = sel_q;
    assign cache_rd_addr   = addr_q;
    assign cache_dec       = fetch_c & ~zero_fill_c;
    assign cache_dec_bytes = cache_dec ? popcount(beat_strb_c) : '0;

    assign WDATA  = wdata_q;
    assign WSTRB  = wstrb_q;
    assign WLAST  = wlast_q;
    assign WVALID = wvalid_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        beats_d  = beats_q;
        lstrb_d  = lstrb_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        wlast_d  = wlast_q;
        wvalid_d = wvalid_q;
        fetch_c  = 1'b0;
`ifdef DMA_WR_DRAIN_ABORT_EN
        abort_d  = abort_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = start_sel;
                    addr_d  = start_addr;
                    beats_d = start_beats;
                    lstrb_d = last_strb;
`ifdef DMA_WR_DRAIN_ABORT_EN
                    abort_d = 1'b0;
`endif
                    state_d = (start_beats != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                fetch_c = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // WVALID is always high here; a handshake either ends or refills.
                if (WREADY) begin
                    if (wlast_q) begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        wstrb_d  = '0;
                        wdata_d  = '0;
                        state_d  = S_DONE;
                    end else begin
                        fetch_c = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef DMA_WR_DRAIN_ABORT_EN
        if ((state_q == S_FETCH || state_q == S_STREAM) && abort) abort_d = 1'b1;
`endif

        if (fetch_c) begin
            wdata_d  = zero_fill_c ? '0 : cache_rd_data;
            wstrb_d  = zero_fill_c ? '0 : beat_strb_c;
            wlast_d  = (beats_q == BW'(1));
            wvalid_d = 1'b1;
            addr_d   = addr_q + AW'(1);
            beats_d  = beats_q - BW'(1);
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_STREAM);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= S_IDLE;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            beats_q  <= '0;
            lstrb_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            wlast_q  <= 1'b0;
            wvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef DMA_WR_DRAIN_ABORT_EN
            abort_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            beats_q  <= beats_d;
            lstrb_q  <= lstrb_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            wlast_q  <= wlast_d;
            wvalid_q <= wvalid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef DMA_WR_DRAIN_ABORT_EN
            abort_q  <= abort_d;
`endif
        end
    end

endmodule
